// File: rtl/sd_io_arbiter.sv
// sd_io_arbiter
// Shares one io-controller sector channel between two SD-card front-ends.
// One sector transfer at a time, round-robin on ties. The granted drive's
// LBA and direction go upstream. Data strobes are routed only to the granted
// drive. The byte count is checked when the transfer ends, and a request that
// never gets io_ack is aborted after REQ_TIMEOUT cycles.
module sd_io_arbiter #(
    parameter int          SECTOR_BYTES = 512,
    parameter logic [23:0] REQ_TIMEOUT  = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset_n,

    // drive-side request channel
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [31:0] req_lba0,
    input  logic [31:0] req_lba1,
    output logic [1:0]  req_ack,
    input  logic [7:0]  req_dout0,
    input  logic [7:0]  req_dout1,
    output logic [7:0]  req_din,
    output logic [1:0]  req_din_strobe,
    output logic [1:0]  req_dout_strobe,

    // io-controller side
    output logic [31:0] io_lba,
    output logic        io_rd,
    output logic        io_wr,
    output logic        io_drive,
    input  logic        io_ack,
    input  logic [7:0]  io_din,
    input  logic        io_din_strobe,
    output logic [7:0]  io_dout,
    input  logic        io_dout_strobe,
    input  logic        io_conf_sel,

    // error pulses
    output logic        err_len,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [9:0]  CNT_EXP  = 10'(SECTOR_BYTES);
    localparam logic [9:0]  CNT_MAX  = 10'h3FF;
    localparam logic [23:0] TMO_LAST = REQ_TIMEOUT - 24'd1;

    state_t      state_q,   state_d;
    logic        g_q,       g_d;        // granted drive
    logic        last_q,    last_d;     // drive served by the last completed transfer
    logic [31:0] lba_q,     lba_d;
    logic        rd_dir_q,  rd_dir_d;   // 1 = read, 0 = write
    logic        io_rd_q,   io_rd_d;
    logic        io_wr_q,   io_wr_d;
    logic [1:0]  ack_q,     ack_d;
    logic [9:0]  cnt_q,     cnt_d;      // strobes seen in XFER, saturating
    logic [23:0] tmo_q,     tmo_d;      // cycles spent in REQ
    logic        len_bad_q, len_bad_d;  // staged so err_len lines up with req_ack
    logic        err_len_q, err_len_d;
    logic        din_stb_q;
    logic        dout_stb_q;

    logic [1:0]  pend;
    logic        pend_g;
    logic        din_rise;
    logic        dout_rise;
    logic        xfer_rise;
    logic        grant_sel;

    assign pend      = req_rd | req_wr;
    assign pend_g    = pend[g_q];
    assign din_rise  = io_din_strobe  & ~din_stb_q;
    assign dout_rise = io_dout_strobe & ~dout_stb_q;
    assign xfer_rise = rd_dir_q ? din_rise : dout_rise;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            g_q       <= 1'b0;
            last_q    <= 1'b1;
            lba_q     <= '0;
            rd_dir_q  <= 1'b0;
            io_rd_q   <= 1'b0;
            io_wr_q   <= 1'b0;
            ack_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            len_bad_q <= 1'b0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            last_q    <= last_d;
            lba_q     <= lba_d;
            rd_dir_q  <= rd_dir_d;
            io_rd_q   <= io_rd_d;
            io_wr_q   <= io_wr_d;
            ack_q     <= ack_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            len_bad_q <= len_bad_d;
            err_len_q <= err_len_d;
        end
    end

    // Previous strobe levels for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_stb_q  <= 1'b0;
            dout_stb_q <= 1'b0;
        end else begin
            din_stb_q  <= io_din_strobe;
            dout_stb_q <= io_dout_strobe;
        end
    end

    // Round-robin pick: on a tie the drive not served last wins
    always_comb begin
        grant_sel = 1'b0;
        if (pend == 2'b11) begin
            grant_sel = ~last_q;
        end else begin
            grant_sel = pend[1];
        end
    end

    // Next-state and registered-output logic of the transfer FSM
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        last_d    = last_q;
        lba_d     = lba_q;
        rd_dir_d  = rd_dir_q;
        io_rd_d   = 1'b0;
        io_wr_d   = 1'b0;
        ack_d     = '0;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        len_bad_d = 1'b0;
        err_len_d = len_bad_q;

        case (state_q)
            S_IDLE: begin
                if (|pend) begin
                    g_d      = grant_sel;
                    lba_d    = grant_sel ? req_lba1 : req_lba0;
                    rd_dir_d = req_rd[grant_sel];
                    cnt_d    = '0;
                    tmo_d    = '0;
                    state_d  = S_REQ;
                end
            end

            S_REQ: begin
                if (io_ack) begin
                    // io_rd/io_wr drop on the edge that sees io_ack
                    state_d = S_XFER;
                end else if (!pend_g) begin
                    // requester withdrew; no ack and round-robin order is kept
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_DONE;
                end else begin
                    tmo_d   = tmo_q + 24'd1;
                    io_rd_d = rd_dir_q;
                    io_wr_d = ~rd_dir_q;
                end
            end

            S_XFER: begin
                if (xfer_rise && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 10'd1;
                end
                if (!io_ack) begin
                    len_bad_d = (cnt_q != CNT_EXP);
                    state_d   = S_DONE;
                end
            end

            S_DONE: begin
                last_d = g_q;
                if (pend_g) begin
                    ack_d[g_q] = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobe routing: data strobes go to the granted drive while the
    // controller holds io_ack; with io_ack low they are configuration bytes
    always_comb begin
        req_din_strobe  = '0;
        req_dout_strobe = '0;
        if (io_ack) begin
            if ((state_q == S_REQ) || (state_q == S_XFER)) begin
                req_din_strobe[g_q]  = io_din_strobe;
                req_dout_strobe[g_q] = io_dout_strobe;
            end
        end else begin
            req_din_strobe[io_conf_sel] = io_din_strobe;
        end
    end

    assign req_din     = io_din;
    assign io_dout     = g_q ? req_dout1 : req_dout0;
    assign io_lba      = lba_q;
    assign io_rd       = io_rd_q;
    assign io_wr       = io_wr_q;
    assign io_drive    = g_q;
    assign req_ack     = ack_q;
    assign err_len     = err_len_q;
    // high during the last REQ cycle before the abort
    assign err_timeout = (state_q == S_REQ) && !io_ack && pend_g && (tmo_q == TMO_LAST);

endmodule

// File: tb/tb_sd_io_arbiter.sv
// Bench for sd_io_arbiter: routing table, directed transfers, cancel,
// timeout, config strobes and randomized transfers against a
// transaction-level round-robin model.
module tb_sd_io_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req_rd = '0;
    logic [1:0]  req_wr = '0;
    logic [31:0] req_lba0 = '0;
    logic [31:0] req_lba1 = '0;
    logic [1:0]  req_ack;
    logic [7:0]  req_dout0 = '0;
    logic [7:0]  req_dout1 = '0;
    logic [7:0]  req_din;
    logic [1:0]  req_din_strobe;
    logic [1:0]  req_dout_strobe;
    logic [31:0] io_lba;
    logic        io_rd, io_wr, io_drive;
    logic        io_ack = 1'b0;
    logic [7:0]  io_din = '0;
    logic        io_din_strobe = 1'b0;
    logic [7:0]  io_dout;
    logic        io_dout_strobe = 1'b0;
    logic        io_conf_sel = 1'b0;
    logic        err_len, err_timeout;

    sd_io_arbiter #(.SECTOR_BYTES(512), .REQ_TIMEOUT(24'd16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_rd(req_rd), .req_wr(req_wr),
        .req_lba0(req_lba0), .req_lba1(req_lba1),
        .req_ack(req_ack),
        .req_dout0(req_dout0), .req_dout1(req_dout1),
        .req_din(req_din),
        .req_din_strobe(req_din_strobe), .req_dout_strobe(req_dout_strobe),
        .io_lba(io_lba), .io_rd(io_rd), .io_wr(io_wr), .io_drive(io_drive),
        .io_ack(io_ack), .io_din(io_din), .io_din_strobe(io_din_strobe),
        .io_dout(io_dout), .io_dout_strobe(io_dout_strobe),
        .io_conf_sel(io_conf_sel),
        .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // observed strobe edges and error pulses
    logic ds0, ds1, os0, os1;
    assign ds0 = req_din_strobe[0];
    assign ds1 = req_din_strobe[1];
    assign os0 = req_dout_strobe[0];
    assign os1 = req_dout_strobe[1];
    int n_din0 = 0, n_din1 = 0, n_dout0 = 0, n_dout1 = 0;
    int n_elen = 0, n_etmo = 0;
    always @(posedge ds0) n_din0++;
    always @(posedge ds1) n_din1++;
    always @(posedge os0) n_dout0++;
    always @(posedge os1) n_dout1++;
    always @(posedge clk) begin
        if (err_len)     n_elen++;
        if (err_timeout) n_etmo++;
    end

    int vecs = 0;
    int errs = 0;
    int last_g = 1;   // model: drive served by the last completed transfer

    task automatic chk(input string nm, input longint act, input longint exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // One request episode: the bench plays both the drives and the io
    // controller. Model: tie -> drive other than last served; byte count
    // error iff strobes != 512; ack two cycles after io_ack falls.
    task automatic run(input logic [1:0] rd, input logic [1:0] wr,
                       input logic [31:0] l0, input logic [31:0] l1, input int nstb);
        logic [1:0]  pend;
        logic [31:0] lba [2];
        logic [7:0]  v;
        int g, n, s_d0, s_d1, s_o0, s_o1, e0;
        bit first;
        lba[0] = l0; lba[1] = l1;
        req_lba0 = l0; req_lba1 = l1;
        req_rd = rd; req_wr = wr;
        pend = rd | wr;
        first = 1;
        while (pend != 2'b00) begin
            g = (pend == 2'b11) ? 1 - last_g : (pend[1] ? 1 : 0);
            n = 0;
            do begin cyc(); n++; end while (!(io_rd | io_wr) && n < 40);
            if (!(io_rd | io_wr)) begin
                chk("grant_seen", 0, 1);
                req_rd = '0; req_wr = '0;
                cyc(40);
                return;
            end
            if (first) chk("grant_latency", n, 2);
            chk("io_drive", io_drive, g);
            chk("io_lba", io_lba, lba[g]);
            chk("io_rd", io_rd, rd[g]);
            chk("io_wr", io_wr, !rd[g]);
            cyc();
            chk("rdwr_hold", io_rd | io_wr, 1);
            io_ack = 1'b1;
            cyc();
            chk("rdwr_clear", io_rd | io_wr, 0);
            s_d0 = n_din0; s_d1 = n_din1; s_o0 = n_dout0; s_o1 = n_dout1;
            e0 = n_elen;
            for (int i = 0; i < nstb; i++) begin
                if (rd[g]) begin
                    io_din = 8'($urandom);
                    io_din_strobe = 1'b1;
                    #1 if (i < 4) chk("req_din", req_din, io_din);
                end else begin
                    v = 8'($urandom);
                    req_dout0 = 8'($urandom);
                    req_dout1 = 8'($urandom);
                    if (g == 1) req_dout1 = v; else req_dout0 = v;
                    io_dout_strobe = 1'b1;
                    #1 chk("io_dout", io_dout, v);
                end
                cyc();
                io_din_strobe = 1'b0;
                io_dout_strobe = 1'b0;
                cyc();
            end
            io_ack = 1'b0;
            n = 0;
            do begin cyc(); n++; end while (req_ack == 2'b00 && n < 40);
            chk("ack_latency", n, 2);
            chk("req_ack", req_ack, (g == 1) ? 2 : 1);
            chk("err_len_at_ack", err_len, (nstb != 512) ? 1 : 0);
            chk("din_strobes_d0",  n_din0  - s_d0, (rd[g] && g == 0) ? nstb : 0);
            chk("din_strobes_d1",  n_din1  - s_d1, (rd[g] && g == 1) ? nstb : 0);
            chk("dout_strobes_d0", n_dout0 - s_o0, (!rd[g] && g == 0) ? nstb : 0);
            chk("dout_strobes_d1", n_dout1 - s_o1, (!rd[g] && g == 1) ? nstb : 0);
            last_g = g;
            req_rd[g] = 1'b0; req_wr[g] = 1'b0;
            rd[g] = 1'b0;
            pend[g] = 1'b0;
            cyc();
            chk("ack_release", req_ack, 0);
            chk("err_len_count", n_elen - e0, (nstb != 512) ? 1 : 0);
            first = 0;
        end
    endtask

    typedef struct {
        logic       ack, sel, dstb, ostb;
        logic [7:0] din, d0, d1;
        logic [1:0] e_dstb, e_ostb;
    } tvec_t;

    initial begin
        tvec_t tv [6];
        int s0, s1, e1, exp0, exp1, n;
        logic [1:0] rr, ww;
        int nstb;

        tv[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 8'h11, 8'h22, 2'b01, 2'b00};
        tv[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h33, 8'h44, 2'b10, 2'b00};
        tv[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h55, 8'h66, 2'b00, 2'b00};
        tv[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hFE, 8'h77, 8'h88, 2'b00, 2'b00};
        tv[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h99, 8'hAA, 2'b00, 2'b00};
        tv[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hBB, 8'hCC, 2'b00, 2'b00};

        // reset state
        cyc(2);
        chk("rst_io_rd", io_rd, 0);
        chk("rst_io_wr", io_wr, 0);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_io_lba", io_lba, 0);
        chk("rst_io_drive", io_drive, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_err_timeout", err_timeout, 0);
        reset_n = 1'b1;
        cyc();

        // idle routing table (g = 0 after reset)
        for (int i = 0; i < 6; i++) begin
            io_ack = tv[i].ack; io_conf_sel = tv[i].sel;
            io_din_strobe = tv[i].dstb; io_dout_strobe = tv[i].ostb;
            io_din = tv[i].din; req_dout0 = tv[i].d0; req_dout1 = tv[i].d1;
            #1;
            chk("tbl_din_strobe", req_din_strobe, tv[i].e_dstb);
            chk("tbl_dout_strobe", req_dout_strobe, tv[i].e_ostb);
            chk("tbl_req_din", req_din, tv[i].din);
            chk("tbl_io_dout", io_dout, tv[i].d0);
            cyc();
        end
        io_ack = 1'b0; io_conf_sel = 1'b0; io_din_strobe = 1'b0; io_dout_strobe = 1'b0;
        cyc(2);

        // simultaneous reads: 0 then 1, twice
        run(2'b11, 2'b00, 32'h0000_1000, 32'h0000_2000, 512);
        run(2'b11, 2'b00, 32'h0000_3000, 32'h0000_4000, 512);
        // drive 0 read
        run(2'b01, 2'b00, 32'h0000_1234, 32'hDEAD_BEEF, 512);
        // drive 1 write
        run(2'b00, 2'b10, 32'h0000_0000, 32'h0055_AA00, 512);

        // drive 0 cancels during REQ
        e1 = n_elen; s0 = n_etmo;
        req_rd = 2'b01; req_lba0 = 32'h0000_0777;
        cyc(2);
        chk("cancel_io_rd_up", io_rd, 1);
        req_rd = 2'b00;
        cyc();
        chk("cancel_io_rd_drop", io_rd, 0);
        for (int i = 0; i < 3; i++) begin
            chk("cancel_no_ack", req_ack, 0);
            cyc();
        end
        chk("cancel_no_err", (n_elen - e1) + (n_etmo - s0), 0);
        // tie after the cancel still goes to drive 0
        run(2'b11, 2'b00, 32'h0000_5000, 32'h0000_6000, 512);

        // timeout: drive 1 write, io_ack never comes
        s0 = n_etmo;
        req_wr = 2'b10; req_lba1 = 32'h0ABC_0001;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            chk("tmo_pulse", err_timeout, (i == 16) ? 1 : 0);
        end
        cyc();
        chk("tmo_ack_not_yet", req_ack, 0);
        cyc();
        chk("tmo_ack", req_ack, 2'b10);
        chk("tmo_count", n_etmo - s0, 1);
        cyc(3);
        chk("tmo_ack_held", req_ack, 2'b10);
        req_wr = 2'b00;
        last_g = 1;
        cyc();
        chk("tmo_ack_release", req_ack, 0);
        cyc();

        // short read
        run(2'b01, 2'b00, 32'h0000_00AB, 32'h0000_00CD, 500);

        // configuration strobes to drive 1
        s0 = n_din0; s1 = n_din1;
        io_conf_sel = 1'b1;
        for (int i = 0; i < 33; i++) begin
            io_din_strobe = 1'b1; cyc();
            io_din_strobe = 1'b0; cyc();
        end
        chk("conf_d1", n_din1 - s1, 33);
        chk("conf_d0", n_din0 - s0, 0);

        // random configuration strobes
        s0 = n_din0; s1 = n_din1; exp0 = 0; exp1 = 0;
        for (int i = 0; i < 40; i++) begin
            io_conf_sel = 1'($urandom_range(0, 1));
            if (io_conf_sel) exp1++; else exp0++;
            io_din_strobe = 1'b1; cyc();
            io_din_strobe = 1'b0; cyc();
        end
        chk("rconf_d0", n_din0 - s0, exp0);
        chk("rconf_d1", n_din1 - s1, exp1);
        io_conf_sel = 1'b0;
        cyc(2);

        // randomized transfers
        for (int r = 0; r < 8; r++) begin
            rr = 2'($urandom_range(0, 3));
            ww = 2'($urandom_range(0, 3));
            if ((rr | ww) == 2'b00) rr = 2'b01;
            nstb = ($urandom_range(0, 1) == 1) ? 512 : int'($urandom_range(480, 520));
            run(rr, ww, $urandom, $urandom, nstb);
            cyc($urandom_range(0, 3));
        end

        // asynchronous reset while a request is outstanding
        req_rd = 2'b10;
        cyc(2);
        n = io_rd ? 1 : 0;
        chk("arst_pre", n, 1);
        #2 reset_n = 1'b0;
        #1 chk("arst_io_rd", io_rd, 0);
        chk("arst_req_ack", req_ack, 0);
        req_rd = 2'b00;
        cyc();
        reset_n = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
